// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for the register-file debug reader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cpu_pkg;

   localparam int REG_ADDR_W = 5;   // 32 architectural registers
   localparam int DATA_W     = 32;  // register width

   typedef enum logic [1:0] {
      IDLE,
      ARB,
      STALL,
      RESP
   } dbg_state_t;

   // Response payload held stable while dbg_rsp_valid waits for ready.
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              stalled;
   } dbg_rsp_t;

endpackage

// File: rtl/regfile_dbg_reader.sv
// Debug readback agent: borrows RF read port B when decode leaves it idle, else forces a 1-cycle stall.
// Latency: 1 cycle for r0, 2 cycles unstalled, 2+MAX_WAIT cycles when a stall is forced.
// Backpressure: one transaction in flight; req_ready only in IDLE, response held until rsp_ready.
//
// Ports: clk/rst (sync, active-high); dbg_req_* request handshake; dbg_rsp_* response handshake;
//        id_rb_busy/dbg_rb_en/dbg_rb_addr/rf_rb_data port-B borrow; cpu_stall pipeline freeze;
//        wb_* writeback snoop (only used when DBG_WB_BYPASS_EN is defined).
// Optional: DBG_WB_BYPASS_EN forwards a same-cycle writeback into the captured value.
module regfile_dbg_reader
   import cpu_pkg::*;
#(
   parameter int ADDR_W   = cpu_pkg::REG_ADDR_W,
   parameter int DATA_W   = cpu_pkg::DATA_W,
   parameter int MAX_WAIT = 8
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              dbg_req_valid,
   output logic              dbg_req_ready,
   input  logic [ADDR_W-1:0] dbg_req_addr,
   output logic              dbg_rsp_valid,
   input  logic              dbg_rsp_ready,
   output logic [DATA_W-1:0] dbg_rsp_data,
   output logic              dbg_rsp_stalled,
   input  logic              id_rb_busy,
   output logic              dbg_rb_en,
   output logic [ADDR_W-1:0] dbg_rb_addr,
   input  logic [DATA_W-1:0] rf_rb_data,
   output logic              cpu_stall,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_waddr,
   input  logic [DATA_W-1:0] wb_wdata
);

   localparam int               CNT_W    = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

   dbg_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   dbg_rsp_t          rsp_q,   rsp_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic [DATA_W-1:0] cap_data;

`ifdef DBG_WB_BYPASS_EN
   // RF port B returns the pre-write value; forward a colliding writeback
   // the same way the pipeline does. r0 is hardwired and never forwarded.
   assign cap_data = (wb_we && (wb_waddr == addr_q) && (addr_q != '0)) ? wb_wdata : rf_rb_data;
`else
   assign cap_data = rf_rb_data;
   logic unused_wb;
   assign unused_wb = ^{wb_we, wb_waddr, wb_wdata};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rsp_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rsp_q   <= rsp_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      rsp_d         = rsp_q;
      cnt_d         = cnt_q;
      dbg_req_ready = 1'b0;
      dbg_rsp_valid = 1'b0;
      dbg_rb_en     = 1'b0;
      cpu_stall     = 1'b0;

      case (state_q)
         IDLE: begin
            dbg_req_ready = 1'b1;
            if (dbg_req_valid) begin
               addr_d = dbg_req_addr;
               cnt_d  = '0;
               if (dbg_req_addr == '0) begin
                  // r0 reads as zero; no need to touch the port.
                  rsp_d.data    = '0;
                  rsp_d.stalled = 1'b0;
                  state_d       = RESP;
               end else begin
                  state_d = ARB;
               end
            end
         end
         ARB: begin
            if (!id_rb_busy) begin
               dbg_rb_en     = 1'b1;
               rsp_d.data    = cap_data;
               rsp_d.stalled = 1'b0;
               state_d       = RESP;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STALL;
            end else begin
               // Saturates at CNT_LAST: the STALL exit above fires first.
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STALL: begin
            // Decode re-issues its port-B read after the stall, so we own the port now.
            cpu_stall     = 1'b1;
            dbg_rb_en     = 1'b1;
            rsp_d.data    = cap_data;
            rsp_d.stalled = 1'b1;
            state_d       = RESP;
         end
         RESP: begin
            dbg_rsp_valid = 1'b1;
            if (dbg_rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Registers only clear at the edge; keep every output quiet for the whole reset cycle.
      if (rst) begin
         dbg_req_ready = 1'b0;
         dbg_rsp_valid = 1'b0;
         dbg_rb_en     = 1'b0;
         cpu_stall     = 1'b0;
      end
   end

   assign dbg_rsp_data    = rst ? '0 : rsp_q.data;
   assign dbg_rsp_stalled = rst ? 1'b0 : rsp_q.stalled;
   assign dbg_rb_addr     = dbg_rb_en ? addr_q : '0;

endmodule
